// File: rtl/sort_collect.sv
// sort_collect: gathers 32 (data, rank) beats into a rank-indexed buffer, then
// streams the buffer out in ascending rank order. Duplicate ranks are flagged.
module sort_collect #(
  parameter int DATASIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vld_in,
  input  logic [DATASIZE-1:0] din,
  input  logic [4:0]          score_in,
  output logic                in_rdy,
  input  logic                dout_rdy,
  output logic                vld_out,
  output logic [DATASIZE-1:0] dout,
  output logic [4:0]          dout_idx,
  output logic                dout_last,
  output logic                dup_err,
  output logic                state_dbg
);

  typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [DATASIZE-1:0] slot_q [32];
  logic [31:0]         wr_mask;
  logic [5:0]          cnt;
  logic [4:0]          rd_ptr;
  logic                accept, handshake, frame_full, frame_done;

  // Both ports transfer on a rising edge where valid and ready are high together;
  // valid never depends on ready, and ready never depends on valid.
  assign accept     = vld_in && (state == COLLECT);
  assign handshake  = dout_rdy && (state == DRAIN);
  assign frame_full = accept && (cnt == 6'd31);
  assign frame_done = handshake && (rd_ptr == 5'd31);

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    vld_out   = 1'b0;
    case (state)
      COLLECT: begin
        in_rdy = 1'b1;
        if (frame_full) state_nxt = DRAIN;
      end
      DRAIN: begin
        vld_out = 1'b1;
        if (frame_done) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      wr_mask <= '0;
      cnt     <= '0;
      rd_ptr  <= '0;
      dup_err <= 1'b0;
      for (int i = 0; i < 32; i++) slot_q[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        slot_q[score_in]  <= din;
        wr_mask[score_in] <= 1'b1;
        cnt               <= cnt + 6'd1;
        if (wr_mask[score_in]) dup_err <= 1'b1;
        if (frame_full) rd_ptr <= '0;
      end
      if (handshake) begin
        // rd_ptr wraps 31 -> 0 exactly as the frame is retired.
        rd_ptr <= rd_ptr + 5'd1;
        if (frame_done) begin
          cnt     <= '0;
          wr_mask <= '0;
          dup_err <= 1'b0;
          for (int i = 0; i < 32; i++) slot_q[i] <= '0;
        end
      end
    end
  end

  assign dout      = slot_q[rd_ptr];
  assign dout_idx  = rd_ptr;
  assign dout_last = vld_out && (rd_ptr == 5'd31);
  assign state_dbg = state;

endmodule
